// File: rtl/buffer_port_arbiter.sv
// ---------------------------------------------------------------------------
// buffer_port_arbiter
//
// Purpose:
//   Shares one single-port on-chip buffer between NumReq requesters.
//   A round-robin arbiter picks at most one request per cycle.
//   The winner's access becomes a registered read or write command to the
//   buffer on the following cycle.
//   Read data returns two cycles after the grant. It goes to the requester
//   that issued the read.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   req           per-requester request, held until granted
//   req_we        per-requester direction, 1 = write, 0 = read
//   req_addr      flattened addresses, slice i = [i*AddrWidth +: AddrWidth]
//   req_wdata     flattened write data, slice i = [i*DataWidth +: DataWidth]
//   gnt           combinational one-hot grant
//   rd_valid      one-hot read-return strobe
//   rd_data       shared read data, qualified by rd_valid
//   buf_write_en  buffer write command (registered)
//   buf_read_en   buffer read command (registered)
//   buf_addr      buffer address (registered)
//   buf_data_in   buffer write data (registered)
//   buf_data_out  buffer read data (1-cycle registered read inside buffer)
// ---------------------------------------------------------------------------
module buffer_port_arbiter #(
  parameter int DataWidth = 8,
  parameter int BuffDepth = 256,
  parameter int AddrWidth = $clog2(BuffDepth),
  parameter int NumReq    = 2,
  parameter int ReqIdxW   = $clog2(NumReq)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NumReq-1:0]             req,
  input  logic [NumReq-1:0]             req_we,
  input  logic [NumReq*AddrWidth-1:0]   req_addr,
  input  logic [NumReq*DataWidth-1:0]   req_wdata,
  output logic [NumReq-1:0]             gnt,
  output logic [NumReq-1:0]             rd_valid,
  output logic [DataWidth-1:0]          rd_data,
  output logic                          buf_write_en,
  output logic                          buf_read_en,
  output logic [AddrWidth-1:0]          buf_addr,
  output logic [DataWidth-1:0]          buf_data_in,
  input  logic [DataWidth-1:0]          buf_data_out
);

  // Round-robin priority pointer: the requester searched first this cycle.
  logic [ReqIdxW-1:0]   ptr;

  // Arbitration result for the current cycle.
  logic                 gnt_any;
  logic [ReqIdxW-1:0]   gnt_idx;

  // Access fields of the winning requester.
  logic                 sel_we;
  logic [AddrWidth-1:0] sel_addr;
  logic [DataWidth-1:0] sel_wdata;

  // Read-return tag pipeline.
  // Stage 1 lines up with the read command.
  // Stage 2 lines up with the buffer's registered data.
  logic                 tag1_valid;
  logic [ReqIdxW-1:0]   tag1_idx;
  logic                 tag2_valid;
  logic [ReqIdxW-1:0]   tag2_idx;

  // Search upward from the pointer with wrap-around; the first set request
  // wins. Reset masks the grant so nothing is accepted while rst_n is low.
  always_comb begin
    int                 cand;
    logic [ReqIdxW-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    for (int off = 0; off < NumReq; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NumReq) begin
        cand = cand - NumReq;
      end
      cand_idx = ReqIdxW'(cand);
      if (!gnt_any && req[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    if (!rst_n) begin
      gnt_any = 1'b0;
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_we    = req_we[gnt_idx];
    sel_addr  = req_addr[int'(gnt_idx)*AddrWidth +: AddrWidth];
    sel_wdata = req_wdata[int'(gnt_idx)*DataWidth +: DataWidth];
  end

  // Command registers, pointer update and read-tag pipeline.
  // The two enables come from one direction bit, so they are never high
  // together. Address and data hold when there is nothing to issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      buf_write_en <= 1'b0;
      buf_read_en  <= 1'b0;
      buf_addr     <= '0;
      buf_data_in  <= '0;
      tag1_valid   <= 1'b0;
      tag1_idx     <= '0;
      tag2_valid   <= 1'b0;
      tag2_idx     <= '0;
    end else begin
      buf_write_en <= gnt_any & sel_we;
      buf_read_en  <= gnt_any & ~sel_we;
      if (gnt_any) begin
        ptr      <= (gnt_idx == ReqIdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
        buf_addr <= sel_addr;
        if (sel_we) begin
          buf_data_in <= sel_wdata;
        end
      end
      tag1_valid <= gnt_any & ~sel_we;
      tag1_idx   <= gnt_idx;
      tag2_valid <= tag1_valid;
      tag2_idx   <= tag1_idx;
    end
  end

  // Returned data is shared; only the strobe is steered to the reader.
  always_comb begin
    rd_valid = '0;
    if (tag2_valid) begin
      rd_valid[tag2_idx] = 1'b1;
    end
  end

  assign rd_data = buf_data_out;

endmodule

// File: tb/tb_buffer_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_buffer_port_arbiter
//
// Purpose:
//   Directed bench for buffer_port_arbiter with two requesters and a
//   256 x 8 buffer.
//   A behavioural single-port buffer is attached to the DUT.
//   It has a 1-cycle registered read and treats read+write as a no-op.
//   It also has a side port so the bench can preload contents.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_buffer_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  gnt;
  logic [1:0]  rd_valid;
  logic [7:0]  rd_data;
  logic        buf_write_en;
  logic        buf_read_en;
  logic [7:0]  buf_addr;
  logic [7:0]  buf_data_in;
  logic [7:0]  buf_data_out;

  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [7:0]  pre_data;
  logic [7:0]  mem [256];

  int checks;
  int errors;

  buffer_port_arbiter #(
    .DataWidth(8),
    .BuffDepth(256),
    .NumReq(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .gnt(gnt),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .buf_write_en(buf_write_en),
    .buf_read_en(buf_read_en),
    .buf_addr(buf_addr),
    .buf_data_in(buf_data_in),
    .buf_data_out(buf_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural buffer. The preload port takes priority over DUT commands.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (buf_write_en && !buf_read_en) begin
      mem[buf_addr] <= buf_data_in;
    end else if (buf_read_en && !buf_write_en) begin
      buf_data_out <= mem[buf_addr];
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] r, input logic [1:0] we,
                                input logic [7:0] a0, input logic [7:0] a1,
                                input logic [7:0] d0, input logic [7:0] d1);
    req       = r;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  // Inputs change 1 time unit after the rising edge.
  // Checks run 1 unit later, well away from either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_en   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pre_en = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    rst_n = 1'b0;
    apply_stimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset state
    #2;
    check_output("reset_gnt", gnt, 2'b00);
    check_output("reset_wen", buf_write_en, 1'b0);
    check_output("reset_ren", buf_read_en, 1'b0);
    check_output("reset_addr", buf_addr, 8'h00);
    check_output("reset_din", buf_data_in, 8'h00);
    check_output("reset_rdv", rd_valid, 2'b00);

    // Buffer contents: 0x10 = 0xA5, k = k+1 for k in 0..7
    preload(8'h10, 8'hA5);
    for (int k = 0; k < 8; k++) begin
      preload(8'(k), 8'(k + 1));
    end
    rst_n = 1'b1;
    tick();

    // Single read by requester 1
    apply_stimulus(2'b10, 2'b00, 8'h00, 8'h10, 8'h00, 8'h00);
    #1;
    check_output("sr_gnt", gnt, 2'b10);
    tick();
    apply_stimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    check_output("sr_ren", buf_read_en, 1'b1);
    check_output("sr_wen", buf_write_en, 1'b0);
    check_output("sr_addr", buf_addr, 8'h10);
    check_output("sr_rdv_early", rd_valid, 2'b00);
    tick();
    #1;
    check_output("sr_rdv", rd_valid, 2'b10);
    check_output("sr_rdata", rd_data, 8'hA5);
    check_output("sr_ren_off", buf_read_en, 1'b0);
    tick();

    // Contention: both read for 4 cycles (req0 addr 0, req1 addr 1)
    apply_stimulus(2'b11, 2'b00, 8'h00, 8'h01, 8'h00, 8'h00);
    #1;
    check_output("ct_gnt0", gnt, 2'b01);
    tick();
    #1;
    check_output("ct_gnt1", gnt, 2'b10);
    check_output("ct_excl1", {buf_write_en, buf_read_en}, 2'b01);
    tick();
    #1;
    check_output("ct_gnt2", gnt, 2'b01);
    check_output("ct_excl2", {buf_write_en, buf_read_en}, 2'b01);
    check_output("ct_rdv2", rd_valid, 2'b01);
    check_output("ct_rdata2", rd_data, 8'h01);
    tick();
    #1;
    check_output("ct_gnt3", gnt, 2'b10);
    check_output("ct_excl3", {buf_write_en, buf_read_en}, 2'b01);
    check_output("ct_rdv3", rd_valid, 2'b10);
    check_output("ct_rdata3", rd_data, 8'h02);
    tick();
    apply_stimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    check_output("ct_rdv4", rd_valid, 2'b01);
    check_output("ct_rdata4", rd_data, 8'h01);
    tick();
    #1;
    check_output("ct_rdv5", rd_valid, 2'b10);
    check_output("ct_rdata5", rd_data, 8'h02);
    tick();

    // Write 0x3C to 0xFF, then read it back on the next cycle
    apply_stimulus(2'b01, 2'b01, 8'hFF, 8'h00, 8'h3C, 8'h00);
    #1;
    check_output("wr_gnt", gnt, 2'b01);
    tick();
    apply_stimulus(2'b01, 2'b00, 8'hFF, 8'h00, 8'h00, 8'h00);
    #1;
    check_output("wr_gnt_rd", gnt, 2'b01);
    check_output("wr_wen", buf_write_en, 1'b1);
    check_output("wr_ren", buf_read_en, 1'b0);
    check_output("wr_addr", buf_addr, 8'hFF);
    check_output("wr_din", buf_data_in, 8'h3C);
    tick();
    apply_stimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    check_output("raw_ren", buf_read_en, 1'b1);
    check_output("raw_wen", buf_write_en, 1'b0);
    check_output("raw_addr", buf_addr, 8'hFF);
    check_output("raw_din_hold", buf_data_in, 8'h3C);
    tick();
    #1;
    check_output("raw_rdv", rd_valid, 2'b01);
    check_output("raw_rdata", rd_data, 8'h3C);

    // Idle for 5 cycles: nothing issued, address and data hold
    for (int c = 0; c < 5; c++) begin
      tick();
      #1;
      check_output("idle_gnt", gnt, 2'b00);
      check_output("idle_en", {buf_write_en, buf_read_en}, 2'b00);
      check_output("idle_addr", buf_addr, 8'hFF);
      check_output("idle_din", buf_data_in, 8'h3C);
    end
    tick();

    // Pointer held at 1 through idle. Then reset arrives mid-read.
    apply_stimulus(2'b11, 2'b00, 8'h00, 8'h10, 8'h00, 8'h00);
    #1;
    check_output("ptr_hold_gnt", gnt, 2'b10);
    tick();
    apply_stimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    check_output("mr_ren", buf_read_en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mr_ren_rst", buf_read_en, 1'b0);
    check_output("mr_addr_rst", buf_addr, 8'h00);
    check_output("mr_din_rst", buf_data_in, 8'h00);
    check_output("mr_rdv_rst", rd_valid, 2'b00);
    apply_stimulus(2'b11, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    check_output("mr_gnt_rst", gnt, 2'b00);
    apply_stimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    rst_n = 1'b1;
    tick();
    #1;
    check_output("mr_rdv_after0", rd_valid, 2'b00);
    tick();
    #1;
    check_output("mr_rdv_after1", rd_valid, 2'b00);
    tick();
    apply_stimulus(2'b11, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    check_output("mr_first_gnt", gnt, 2'b01);
    tick();
    apply_stimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();

    // Throughput: 8 back-to-back reads by requester 0, buffer[k] = k+1
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        apply_stimulus(2'b01, 2'b00, 8'(k), 8'h00, 8'h00, 8'h00);
      end else begin
        apply_stimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      end
      #1;
      if (k < 8) begin
        check_output("tp_gnt", gnt, 2'b01);
      end
      if (k >= 2) begin
        check_output("tp_rdv", rd_valid, 2'b01);
        check_output("tp_rdata", rd_data, 32'(k - 1));
      end
      tick();
    end
    #1;
    check_output("tp_rdv_end", rd_valid, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffer_port_arbiter.md
Name: buffer_port_arbiter

Overview:
- Shares one single-port on-chip buffer (DataWidth x BuffDepth, 1-cycle registered read) between NumReq requesters, e.g. a DMA loader and the PE array feeders.
- Round-robin arbitration selects one request per cycle.
- Issues registered one-hot read/write commands to the buffer and routes returned read data to the requester that issued the read.
- Never drives read and write together, because the buffer treats that combination as a no-op.

Parameters:
- DataWidth, 8, buffer word width.
- BuffDepth, 256, buffer depth in words.
- AddrWidth, $clog2(BuffDepth), buffer address width.
- NumReq, 2, number of requesters (>=2).
- ReqIdxW, $clog2(NumReq), requester index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NumReq  per-requester request; held until granted.
- req_we  in  NumReq  1 = write, 0 = read.
- req_addr  in  NumReq*AddrWidth  flattened per-requester address; slice i = [i*AddrWidth +: AddrWidth].
- req_wdata  in  NumReq*DataWidth  flattened per-requester write data.
- gnt  out  NumReq  one-hot grant; combinational; request accepted when req[i] & gnt[i].
- rd_valid  out  NumReq  one-hot; read data valid for requester i.
- rd_data  out  DataWidth  read data, shared across requesters; qualified by rd_valid.
- buf_write_en  out  1  to buffer write_en.
- buf_read_en  out  1  to buffer read_en.
- buf_addr  out  AddrWidth  to buffer addr.
- buf_data_in  out  DataWidth  to buffer data_in.
- buf_data_out  in  DataWidth  from buffer data_out.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Priority pointer = 0.
  - buf_write_en, buf_read_en, buf_addr, buf_data_in = 0.
  - Read-return pipeline cleared; rd_valid = 0.
  - gnt forced to 0 while rst_n is low.
- Arbitration, cycle T:
  - Search req starting at the pointer, ascending with wrap modulo NumReq.
  - The first set bit wins and gets gnt.
  - If req == 0: gnt = 0 and the pointer holds.
  - On a grant to i, the pointer becomes (i+1) mod NumReq at the edge ending T.
  - At most one grant per cycle, so sustained throughput is 1 access/cycle.
- Command issue, cycle T+1 (registered):
  - Write grant: buf_write_en=1, buf_read_en=0, buf_addr and buf_data_in = the granted slices.
  - Read grant: buf_read_en=1, buf_write_en=0, buf_addr = granted slice; buf_data_in holds its previous value.
  - No grant: both enables = 0; buf_addr and buf_data_in hold.
  - buf_write_en & buf_read_en is never 1.
- Read return:
  - A 2-stage tag pipeline carries {valid, requester index} of each read.
  - rd_valid[i] = 1 in cycle T+2 only, and rd_data = buf_data_out.
  - Total read latency from grant = 2 cycles.
  - Back-to-back reads from different requesters return in grant order, one per cycle.
- Writes produce no response; the write is complete at the end of T+1.
- Read-after-write, same address, granted on consecutive cycles: the read returns the new data. This follows from the buffer write landing at the end of T+1 and the read command sampling at the end of T+2.
- Requester rules:
  - Requester must keep req, req_we, req_addr and req_wdata stable until it sees gnt.
  - Requester may drop req in the cycle after a grant, or keep it high to issue a new access.
  - Address is passed through unchecked; wrap-around is the requester's responsibility.
- Reset mid-operation: in-flight commands and reads are dropped; no rd_valid is produced for them after rst_n deasserts.
- First arbitration after reset starts at requester 0.

Test Plan:
- Single read: buffer preloaded with addr 0x10=0xA5; req[1]=1, we=0, addr=0x10 at T -> gnt=2'b10 at T; buf_read_en=1, buf_addr=0x10 at T+1; rd_valid=2'b10, rd_data=0xA5 at T+2.
- Contention: req=2'b11 held for 4 cycles after reset -> gnt sequence 01,10,01,10; pointer alternates; no cycle has both buffer enables high.
- Write then read: req0 writes 0x3C to addr 0xFF at T; req0 reads addr 0xFF at T+1 -> buf_write_en at T+1, buf_read_en at T+2, rd_valid[0] with rd_data=0x3C at T+3.
- Idle: req=0 for 5 cycles -> gnt=0, both enables 0, buf_addr unchanged, pointer unchanged.
- Reset mid-read: grant read at T, pull rst_n low mid-cycle T+1 -> all outputs 0 immediately; no rd_valid after release; next grant goes to requester 0 when req=2'b11.
- Throughput: req0 issues 8 consecutive reads (addr 0..7, buffer[k]=k+1) -> 8 consecutive rd_valid[0] cycles with data 1..8 starting 2 cycles after the first grant.
